ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the CPU side to the keyboard over the same open-collector clock/data pair that ps2_kbd receives on. The block runs the full PS/2 request-to-send sequence: it inhibits the clock, issues the start bit, shifts data/parity/stop on device-generated clock edges, then samples the device acknowledge. It sits beside ps2_kbd, shares the pad pair, and drives the pads through active-high open-drain enables.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before the start bit (≥100 µs at the system clock).
- TIMEOUT_CYCLES, 1500000: watchdog limit, in clk cycles, from clock release to acknowledge.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pad level.
- ps2_data  in  1  raw PS/2 data pad level.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_oe  out  1  1 = pull the clock pad low, 0 = release it.
- ps2_data_oe  out  1  1 = pull the data pad low, 0 = release it.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer ends.
- nack  out  1  valid with done: the device did not acknowledge.
- timeout  out  1  valid with done: the watchdog expired.

## Operation
- Input sync: ps2_clk and ps2_data each pass through a 3-flop synchronizer. A falling edge (fe) is sync[2]&~sync[1], so fe is one clk wide. Data is read from sync[1].
- Accept: tx_valid&tx_ready latches tx_data and computes parity = ~^tx_data (odd parity). The block then enters INHIBIT.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0.
  - A counter runs INHIBIT_CYCLES cycles, then the block enters REQ.
- REQ:
  - Lasts one cycle, with ps2_clk_oe=1 and ps2_data_oe=1 (start bit = 0).
  - The block then enters SEND and releases the clock (ps2_clk_oe=0). ps2_data_oe stays 1.
- SEND: a 4-bit edge counter n starts at 0. On each fe, n increments and the data line is set:
  - n=1..8: ps2_data_oe = ~tx_data[n-1], LSB first.
  - n=9: ps2_data_oe = ~parity.
  - n=10: ps2_data_oe = 0 (stop bit, line released). The block then enters ACK.
- ACK: on the next fe, the block samples sync[1]:
  - 0 means ACK; nack is cleared.
  - 1 means NACK; nack is set.
  - The block then enters WAIT_IDLE.
- WAIT_IDLE: when both synchronized lines read 1, the block pulses done and returns to IDLE.
- Watchdog: runs in SEND, ACK and WAIT_IDLE. On expiry the block releases both lines, sets timeout, pulses done and returns to IDLE.
- fe in IDLE, INHIBIT or REQ is ignored, because ps2_kbd owns device-to-host traffic.
- nack and timeout hold their value until the next accept, which clears both.

## Timing
- Reset values: tx_ready=1; ps2_clk_oe, ps2_data_oe, busy, done, nack and timeout all 0. State is IDLE and every counter is 0.
- Reset mid-transfer releases both pads immediately (asynchronous). No done pulse is produced.
- tx_ready falls and ps2_clk_oe rises in the cycle after the accept edge.
- The INHIBIT phase is exactly INHIBIT_CYCLES cycles of ps2_clk_oe=1 before ps2_data_oe rises.
- Each ps2_data_oe update lands 1 clk after the fe detect, which is 3 clk after the pad edge. This is well inside the device's clock-low half-period.
- done is asserted for exactly 1 cycle. tx_ready returns the same cycle and a new accept is allowed that cycle.
- tx_valid while busy is ignored. tx_data is not re-sampled mid-transfer.
- The watchdog counter is wide enough for TIMEOUT_CYCLES, and expires when count == TIMEOUT_CYCLES-1.

## Configuration
- PS2_TX_TIMEOUT_EN defined: the watchdog is compiled in as described above.
- PS2_TX_TIMEOUT_EN undefined: there is no watchdog counter and timeout is tied to 0. A stalled device leaves busy=1 until rst.

## Test plan
The bench uses INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=2000. The device model clocks at a 40-clk period and drives the ACK low.
- Send 0xED: ps2_clk_oe is high for 8 cycles, then the start bit. The device samples bits 1,0,1,1,0,1,1,1, parity=1, stop=1. Response: ACK, done with nack=0 and timeout=0.
- Send 0x07: the device sees parity=0. Send 0x00: the device sees parity=1. Both complete with nack=0.
- Device holds data high at the 11th falling edge: done with nack=1 and timeout=0. The next accept clears nack.
- Device never clocks after the start bit: with PS2_TX_TIMEOUT_EN defined, done, timeout=1 and both oe=0 follow 2000 cycles after clock release. Without the macro, busy stays 1.
- Assert rst after edge 5: both oe go to 0 asynchronously, tx_ready=1 and there is no done pulse. A subsequent 0xFF send completes with parity=1.
- tx_valid pulses while busy, and device edges arrive while IDLE: neither starts a transfer. ps2_clk_oe and ps2_data_oe stay 0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shift and ACK sampling.
// Define PS2_TX_TIMEOUT_EN to compile in the clock-release-to-ACK watchdog.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       timeout
);

   localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StSend,
      StAck,
      StWaitIdle
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      clk_sync_q, data_sync_q;
   logic            clk_fe, clk_s, data_s;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      data_q, data_d;
   logic            parity_q, parity_d;
   logic            clk_oe_q, clk_oe_d;
   logic            data_oe_q, data_oe_d;
   logic            done_q, done_d;
   logic            nack_q, nack_d;

   assign clk_fe = clk_sync_q[2] & ~clk_sync_q[1];
   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   // The data line needs only the level, not an edge, so its last stage is spare.
   logic unused_data_sync;
   assign unused_data_sync = data_sync_q[2];

`ifdef PS2_TX_TIMEOUT_EN
   localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WdW-1:0] wd_q, wd_d;
   logic           timeout_q, timeout_d;
   logic           wd_active, wd_expire;

   assign wd_active = state_q inside {StSend, StAck, StWaitIdle};
   assign wd_expire = wd_active && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
   assign timeout   = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      inh_cnt_d = inh_cnt_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      parity_d  = parity_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      nack_d    = nack_q;
`ifdef PS2_TX_TIMEOUT_EN
      wd_d      = wd_q;
      timeout_d = timeout_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               state_d   = StInhibit;
               data_d    = tx_data;
               parity_d  = ~^tx_data;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               inh_cnt_d = '0;
               bit_cnt_d = '0;
               nack_d    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
            end
         end
         StInhibit: begin
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
               state_d   = StReq;
               data_oe_d = 1'b1;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         StReq: begin
            // Release the clock with data still low: the start bit.
            state_d   = StSend;
            clk_oe_d  = 1'b0;
            bit_cnt_d = '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_d      = '0;
`endif
         end
         StSend: begin
            if (clk_fe) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q < 4'd8) begin
                  data_oe_d = ~data_q[bit_cnt_q[2:0]];
               end else if (bit_cnt_q == 4'd8) begin
                  data_oe_d = ~parity_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = StAck;
               end
            end
         end
         StAck: begin
            if (clk_fe) begin
               nack_d  = data_s;
               state_d = StWaitIdle;
            end
         end
         StWaitIdle: begin
            if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (wd_active) begin
         wd_d = wd_q + 1'b1;
         if (wd_expire) begin
            state_d   = StIdle;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
         inh_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         data_q      <= '0;
         parity_q    <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         nack_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         wd_q        <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[1:0], ps2_data};
         inh_cnt_q   <= inh_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         data_q      <= data_d;
         parity_q    <= parity_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         done_q      <= done_d;
         nack_q      <= nack_d;
`ifdef PS2_TX_TIMEOUT_EN
         wd_q        <= wd_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign tx_ready    = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign nack        = nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector pad model, PS/2 device model and a frame-level reference.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk, ps2_data;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;
   logic       dev_clk_low, dev_data_low;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic last_nack, last_timeout, last_ready;

   always #5 clk = ~clk;

   // Wired-AND pads: either side pulling low wins.
   assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(8),
      .TIMEOUT_CYCLES(2000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .nack       (nack),
      .timeout    (timeout)
   );

   typedef struct {
      logic [7:0] data;
      bit         ack_low;
      bit         pulse_busy;
      logic       exp_parity;
      logic       exp_nack;
   } vec_t;

   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            last_nack    = nack;
            last_timeout = timeout;
            last_ready   = tx_ready;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "bench stuck");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Start bit, LSB-first data, odd parity, stop bit.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d, 1'b0};
   endfunction

   // Device side: waits for the request-to-send, clocks at a 40-clk period, samples on rising edges.
   task automatic device_run(input int max_edges, input bit ack_low,
                             output logic [10:0] frame, output bit started);
      started = 1'b0;
      frame   = '1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ps2_clk === 1'b1 && ps2_data === 1'b0) begin
            started = 1'b1;
            break;
         end
      end
      if (started) begin
         repeat (10) @(negedge clk);
         frame[0] = ps2_data;
         for (int e = 1; e <= 10 && e <= max_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            frame[e] = ps2_data;
            repeat (10) @(negedge clk);
         end
         if (max_edges >= 11) begin
            dev_data_low = ack_low;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            dev_data_low = 1'b0;
         end
      end
   endtask

   task automatic accept(input logic [7:0] d);
      @(posedge clk);
      #1;
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;
   endtask

   task automatic do_send(input logic [7:0] d, input bit ack_low, input bit pulse_busy,
                          output logic [10:0] fr);
      int base;
      int inh;
      bit st;
      base = done_cnt;
      accept(d);
      fork
         device_run(11, ack_low, fr, st);
         begin
            @(negedge clk);
            check("accept_ready_low", tx_ready, 0);
            check("accept_clk_oe", ps2_clk_oe, 1);
            check("accept_flags_clear", {nack, timeout}, 0);
            inh = 0;
            for (int i = 0; i < 50; i++) begin
               if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh++;
               else break;
               @(negedge clk);
            end
            check("inhibit_len", inh, 8);
            check("start_bit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
            if (pulse_busy) begin
               for (int p = 0; p < 4; p++) begin
                  repeat (40) @(posedge clk);
                  #1;
                  tx_valid = 1'b1;
                  tx_data  = 8'($urandom);
                  @(posedge clk);
                  #1;
                  tx_valid = 1'b0;
               end
            end
         end
      join
      for (int i = 0; i < 100 && done_cnt == base; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("device_saw_start", st, 1);
      check("done_pulses", done_cnt - base, 1);
      check("done_timeout", last_timeout, 0);
      check("done_ready", last_ready, 1);
      check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);
   endtask

   initial begin
      vec_t        vecs[5];
      logic [10:0] fr;
      logic [7:0]  d;
      bit          ack, st, rel;
      int          base, cnt, bad;

      vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};

      rst          = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", tx_ready, 1);
      check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("reset_status", {busy, done, nack, timeout}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         do_send(vecs[v].data, vecs[v].ack_low, vecs[v].pulse_busy, fr);
         check("vec_frame", fr, model_frame(vecs[v].data));
         check("vec_parity", fr[9], vecs[v].exp_parity);
         check("vec_nack", last_nack, vecs[v].exp_nack);
      end

      for (int r = 0; r < 6; r++) begin
         d   = 8'($urandom);
         ack = ($urandom_range(0, 3) != 0);
         do_send(d, ack, 1'b0, fr);
         check("rand_frame", fr, model_frame(d));
         check("rand_nack", last_nack, !ack);
      end

      // Stalled device: nothing clocks after the start bit.
      base = done_cnt;
      accept(8'h3C);
      rel = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) begin
            rel = 1'b1;
            break;
         end
      end
      check("stall_release", rel, 1);
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cnt++;
         if (done === 1'b1) break;
      end
`ifdef PS2_TX_TIMEOUT_EN
      check("timeout_latency", cnt, 2000);
      check("timeout_flag", {timeout, nack}, 2'b10);
      check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("timeout_ready", tx_ready, 1);
      repeat (5) @(negedge clk);
      check("timeout_one_done", done_cnt - base, 1);
`else
      check("stall_busy", busy, 1);
      check("stall_no_done", done_cnt - base, 0);
      check("stall_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
`endif

      // Reset after the fifth device edge.
      base = done_cnt;
      accept(8'h00);
      device_run(5, 1'b1, fr, st);
      check("mid_started", st, 1);
      check("mid_data_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_async_ready", {tx_ready, busy}, 2'b10);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("rst_no_done", done_cnt - base, 0);
      do_send(8'hFF, 1'b1, 1'b0, fr);
      check("post_rst_frame", fr, model_frame(8'hFF));
      check("post_rst_parity", fr[9], 1);
      check("post_rst_nack", last_nack, 0);

      // Device traffic while idle must not start anything.
      base = done_cnt;
      bad  = 0;
      for (int i = 0; i < 5; i++) begin
         dev_data_low = i[0];
         dev_clk_low  = 1'b1;
         repeat (20) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) bad++;
         end
         dev_clk_low = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) bad++;
         end
      end
      dev_data_low = 1'b0;
      check("idle_edges_ignored", bad, 0);
      check("idle_edges_no_done", done_cnt - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
